// File: rtl/accumulator_feeder_pkg.sv
// Shared definitions for the accumulator feeder: word width, FSM state
// encoding and the width of the per-group block counter.
// No ports; imported by accumulator_feeder and acc_lane_packer.
package accumulator_feeder_pkg;

  // Word width of every lane and of the accumulator sum.
  localparam int VARWIDTH = 32;

  // Width of the saturating block counter reported on out_blocks.
  localparam int BLKW = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    EMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_lane_packer.sv
// Lane register file feeding the accumulator's packed vals bus.
// Ports: clk/rst (async active-high), wr_en/wr_idx/wr_data indexed write,
// clr zeroes every lane, vals is the packed view (lane i at [32i+31:32i]).
module acc_lane_packer
  import accumulator_feeder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [IW-1:0]             wr_idx,
  input  logic [VARWIDTH-1:0]       wr_data,
  input  logic                      clr,
  output logic [VARWIDTH*WIDTH-1:0] vals
);

  logic [VARWIDTH-1:0] lanes [WIDTH];

  // Clear wins over a write; the FSM never asks for both in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) lanes[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < WIDTH; i++) lanes[i] <= '0;
    end else if (wr_en) begin
      lanes[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pack
    assign vals[g*VARWIDTH +: VARWIDTH] = lanes[g];
  end

endmodule

// File: rtl/accumulator_feeder.sv
// Packs a serial word stream into WIDTH-lane blocks for an accumulator,
// sequences its rst/pre/EN controls, and returns each group's total.
// Ports: in_* word stream (valid/ready, in_last ends a group), out_* group
// result (valid/ready), acc_* accumulator controls, vals bus, rdy and sum.
module accumulator_feeder
  import accumulator_feeder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [VARWIDTH-1:0]       in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [VARWIDTH-1:0]       out_data,
  output logic [BLKW-1:0]           out_blocks,
  input  logic                      out_ready,
  output logic                      acc_en,
  output logic                      acc_rst,
  output logic                      acc_pre,
  output logic [VARWIDTH*WIDTH-1:0] acc_vals,
  input  logic                      acc_rdy,
  input  logic [VARWIDTH-1:0]       acc_sum
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt;
  logic [BLKW-1:0] blk_cnt;
  logic            last_q;
  logic            chained;
  logic            accept;
  logic            block_end;
  logic            lane_clr;

  assign accept    = in_valid && in_ready;
  // A word closes the block if it fills the last lane or carries in_last;
  // both together are one event.
  assign block_end = accept && ((wcnt == CW'(WIDTH - 1)) || in_last);
  assign lane_clr  = ((state_q == RUN) && acc_rdy && !last_q) ||
                     ((state_q == EMIT) && out_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (block_end) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (acc_rdy) state_d = last_q ? EMIT : FILL;
      EMIT:    if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    acc_en    = 1'b0;
    acc_pre   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL:    in_ready  = 1'b1;
      CLEAR:   acc_pre   = chained;
      RUN:     acc_en    = 1'b1;
      EMIT:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Counters, flags and result registers. acc_rst is registered from the
  // next state so it lines up exactly with the CLEAR cycle and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_rst  <= 1'b1;
      wcnt     <= '0;
      blk_cnt  <= '0;
      last_q   <= 1'b0;
      chained  <= 1'b0;
      out_data <= '0;
    end else begin
      acc_rst <= (state_d == CLEAR);
      case (state_q)
        FILL: begin
          if (accept) begin
            wcnt <= wcnt + 1'b1;
            if (block_end) last_q <= in_last;
          end
        end
        RUN: begin
          if (acc_rdy) begin
            if (blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
            if (last_q) begin
              out_data <= acc_sum;
            end else begin
              // Next block continues the same group on top of this total.
              chained <= 1'b1;
              wcnt    <= '0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            chained <= 1'b0;
            blk_cnt <= '0;
            wcnt    <= '0;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_blocks = blk_cnt;

  acc_lane_packer #(
    .WIDTH(WIDTH),
    .IW   (IW)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (accept),
    .wr_idx (wcnt[IW-1:0]),
    .wr_data(in_data),
    .clr    (lane_clr),
    .vals   (acc_vals)
  );

endmodule
